// File: rtl/neuron_cmd_ctrl_pkg.sv
// rtl/neuron_cmd_ctrl_pkg.sv - shared encodings and decoded-byte type for the neuron command controller
package neuron_cmd_ctrl_pkg;

  typedef enum logic [1:0] {
    NEURON_CTRL_IDLE     = 2'd0,
    NEURON_CTRL_CLEAR    = 2'd1,
    NEURON_CTRL_DISPATCH = 2'd2
  } ctrl_state_t;

  typedef enum logic [1:0] {
    NEURON_CFG_THRESH = 2'd0,
    NEURON_CFG_LEAK   = 2'd1,
    NEURON_CFG_REFRAC = 2'd2,
    NEURON_CFG_MODE   = 2'd3
  } cfg_op_t;

  // Command addresses occupy the top of the 6-bit space, so arrays larger than 61 cannot exist.
  localparam logic [5:0] NEURON_CMD_RESET = 6'd63;
  localparam logic [5:0] NEURON_CMD_ARM   = 6'd62;
  localparam logic [5:0] NEURON_CMD_CFG   = 6'd61;

  typedef struct packed {
    logic       is_reset;
    logic       is_arm;
    logic       is_cfg;
    logic       is_event;
    logic       tick;
    logic       polarity;
    logic [5:0] addr;
    cfg_op_t    cfg_op;
    logic [3:0] cfg_arg;
  } decoded_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/neuron_event_decode.sv
// rtl/neuron_event_decode.sv - splits an input byte pair into command or event fields
module neuron_event_decode
  import neuron_cmd_ctrl_pkg::*;
(
  input  logic [7:0] in_data,
  input  logic [7:0] uio_data,
  output decoded_t   dec
);

  logic unused_uio;
  assign unused_uio = ^uio_data[1:0];

  // Tick bytes are never commands, even when their addr bits match a command code.
  always_comb begin
    dec          = '0;
    dec.tick     = in_data[7];
    dec.polarity = in_data[6];
    dec.addr     = in_data[5:0];
    dec.cfg_op   = cfg_op_t'(uio_data[3:2]);
    dec.cfg_arg  = uio_data[7:4];
    dec.is_reset = !in_data[7] && (in_data[5:0] == NEURON_CMD_RESET);
    dec.is_arm   = !in_data[7] && (in_data[5:0] == NEURON_CMD_ARM);
    dec.is_cfg   = !in_data[7] && (in_data[5:0] == NEURON_CMD_CFG);
    dec.is_event = !(dec.is_reset || dec.is_arm || dec.is_cfg);
  end

endmodule

// File: rtl/neuron_cmd_ctrl.sv
// rtl/neuron_cmd_ctrl.sv - byte-level command/event sequencer in front of the neuron array core
module neuron_cmd_ctrl
  import neuron_cmd_ctrl_pkg::*;
#(
  parameter int         NUM_NEURONS    = 32,
  parameter logic [3:0] DEFAULT_THRESH = 4'd8,
  parameter logic [3:0] DEFAULT_LEAK   = 4'd1,
  parameter logic [3:0] DEFAULT_REFRAC = 4'd2,
  parameter logic [3:0] DEFAULT_MODE   = 4'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic [7:0] uio_data,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic       ev_tick,
  output logic       ev_polarity,
  output logic [5:0] ev_addr,
  output logic       clr_en,
  output logic [5:0] clr_addr,
  output logic       armed,
  output logic [3:0] cfg_thresh,
  output logic [3:0] cfg_leak,
  output logic [3:0] cfg_refrac,
  output logic [3:0] cfg_mode,
  output logic [7:0] drop_cnt,
  output logic       busy
);

  localparam logic [5:0] LAST_ADDR = 6'(NUM_NEURONS - 1);

  ctrl_state_t state, state_next;
  decoded_t    dec;
  logic        accept;
  logic        in_range;
  logic        fwd;
  logic        clr_last;

  neuron_event_decode u_decode (
    .in_data  (in_data),
    .uio_data (uio_data),
    .dec      (dec)
  );

  assign in_ready = (state == NEURON_CTRL_IDLE);
  assign busy     = (state != NEURON_CTRL_IDLE);
  assign accept   = in_valid && in_ready;
  assign in_range = ({1'b0, dec.addr} < 7'(NUM_NEURONS));
  assign fwd      = dec.is_event && armed && (dec.tick || in_range);
  assign clr_last = (clr_addr == LAST_ADDR);

  always_ff @(posedge clk) begin
    if (rst) state <= NEURON_CTRL_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      NEURON_CTRL_IDLE: begin
        if (accept) begin
          if (dec.is_reset) state_next = NEURON_CTRL_CLEAR;
          else if (fwd)     state_next = NEURON_CTRL_DISPATCH;
        end
      end
      NEURON_CTRL_CLEAR:    if (clr_last) state_next = NEURON_CTRL_IDLE;
      NEURON_CTRL_DISPATCH: if (ev_ready) state_next = NEURON_CTRL_IDLE;
      default:              state_next = NEURON_CTRL_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ev_valid    <= 1'b0;
      ev_tick     <= 1'b0;
      ev_polarity <= 1'b0;
      ev_addr     <= 6'd0;
      clr_en      <= 1'b0;
      clr_addr    <= 6'd0;
      armed       <= 1'b0;
      cfg_thresh  <= DEFAULT_THRESH;
      cfg_leak    <= DEFAULT_LEAK;
      cfg_refrac  <= DEFAULT_REFRAC;
      cfg_mode    <= DEFAULT_MODE;
      drop_cnt    <= 8'd0;
    end else begin
      case (state)
        NEURON_CTRL_IDLE: begin
          if (accept) begin
            if (dec.is_reset) begin
              // clr_en rises with the state change so address 0 is cleared on the first CLEAR cycle.
              armed      <= 1'b0;
              cfg_thresh <= DEFAULT_THRESH;
              cfg_leak   <= DEFAULT_LEAK;
              cfg_refrac <= DEFAULT_REFRAC;
              cfg_mode   <= DEFAULT_MODE;
              drop_cnt   <= 8'd0;
              clr_addr   <= 6'd0;
              clr_en     <= 1'b1;
            end else if (dec.is_arm) begin
              armed <= dec.cfg_arg[0];
            end else if (dec.is_cfg) begin
              case (dec.cfg_op)
                NEURON_CFG_THRESH: cfg_thresh <= dec.cfg_arg;
                NEURON_CFG_LEAK:   cfg_leak   <= dec.cfg_arg;
                NEURON_CFG_REFRAC: cfg_refrac <= dec.cfg_arg;
                default:           cfg_mode   <= dec.cfg_arg;
              endcase
            end else if (fwd) begin
              ev_valid    <= 1'b1;
              ev_tick     <= dec.tick;
              ev_polarity <= dec.polarity;
              ev_addr     <= dec.addr;
            end else begin
              drop_cnt <= sat_inc8(drop_cnt);
            end
          end
        end
        NEURON_CTRL_CLEAR: begin
          if (clr_last) begin
            clr_en   <= 1'b0;
            clr_addr <= 6'd0;
          end else begin
            clr_addr <= clr_addr + 6'd1;
          end
        end
        NEURON_CTRL_DISPATCH: begin
          if (ev_ready) ev_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/neuron_cmd_ctrl.md
Name: neuron_cmd_ctrl

Overview:
Command and event sequencer between the TinyTapeout input pins and the neuron array core. It accepts one input byte per handshake and decodes it as either a command (reset, arm, cfg) or an event (spike or tick). Commands update the config register bank, update the arm state, or run a multi-cycle state-clear sweep. Armed, in-range events are forwarded to the core over a valid/ready handshake; all other events are dropped and counted.

Parameters:
NUM_NEURONS, 32, neurons covered by the clear sweep and valid event range; legal range 1..61.
DEFAULT_THRESH, 4'd8, threshold value after reset.
DEFAULT_LEAK, 4'd1, leak value after reset.
DEFAULT_REFRAC, 4'd2, refractory period after reset.
DEFAULT_MODE, 4'd0, mode value after reset.

Ports:
clk  input  1  system clock; the only clock.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  in_data/uio_data hold a byte.
in_ready  output  1  byte accepted this cycle when in_valid && in_ready.
in_data  input  8  {tick, polarity, addr[5:0]}.
uio_data  input  8  {cfg_arg[3:0], cfg_op[1:0], 2'b--}.
ev_valid  output  1  event presented to core.
ev_ready  input  1  core accepts event.
ev_tick  output  1  event is a timestep tick.
ev_polarity  output  1  spike polarity.
ev_addr  output  6  target neuron.
clr_en  output  1  core must zero the state of neuron clr_addr this cycle.
clr_addr  output  6  neuron address for the clear sweep.
armed  output  1  event forwarding enabled.
cfg_thresh, cfg_leak, cfg_refrac, cfg_mode  output  4 each  config register bank.
drop_cnt  output  8  saturating count of dropped events.
busy  output  1  state != IDLE.

Behaviour:
- Reset values:
  - State IDLE; in_ready=1; ev_valid=0; ev_tick=0; ev_polarity=0; ev_addr=0.
  - clr_en=0; clr_addr=0; armed=0; drop_cnt=0; cfg_* = DEFAULT_*.
- Decoding uses the existing neuron_event_decode combinationally on in_data/uio_data. Special commands exist only when tick=0.
- States: IDLE, CLEAR, DISPATCH. in_ready = (state==IDLE), combinational from state.
- On acceptance in IDLE, first match wins:
  - RESET cmd: armed<=0, cfg_*<=DEFAULT_*, drop_cnt<=0, clr_addr<=0, go to CLEAR.
  - ARM cmd: armed<=cfg_arg[0]. Stay in IDLE.
  - CFG cmd: cfg_op 0/1/2/3 writes cfg_arg to thresh/leak/refrac/mode. The write is visible the next cycle. Stay in IDLE.
  - Event with armed=1 and (tick=1 or addr<NUM_NEURONS): latch tick/polarity/addr into ev_*, ev_valid<=1, go to DISPATCH.
  - Any other event: dropped; drop_cnt+=1, saturating at 255. Stay in IDLE.
  - Tick events bypass the range check; ev_addr carries the raw addr bits.
- CLEAR:
  - clr_en=1 for exactly NUM_NEURONS consecutive cycles; clr_addr=0..NUM_NEURONS-1, one per cycle.
  - After the cycle with clr_addr=NUM_NEURONS-1: clr_en<=0, clr_addr<=0, return to IDLE.
  - The next byte can be accepted NUM_NEURONS+1 cycles after the RESET acceptance cycle.
- DISPATCH:
  - ev_valid and ev_* hold stable until ev_valid && ev_ready.
  - In that cycle: ev_valid<=0, return to IDLE. Minimum event-to-event interval is 2 cycles.
  - ev_ready is ignored while ev_valid=0.
- Arm state is sampled at acceptance. An ARM cmd with arg 0 cannot overtake an event already in DISPATCH, because inputs are blocked there.
- rst asserted in any state (mid-CLEAR, mid-DISPATCH) restores all reset values next cycle. A pending event is discarded, never presented.
- NUM_NEURONS=1: CLEAR lasts one cycle.

Decomposition:
- Extend neuron_defs.vh with:
  - State encodings: NEURON_CTRL_IDLE=2'd0, NEURON_CTRL_CLEAR=2'd1, NEURON_CTRL_DISPATCH=2'd2.
  - cfg_op codes: NEURON_CFG_THRESH=0, NEURON_CFG_LEAK=1, NEURON_CFG_REFRAC=2, NEURON_CFG_MODE=3.
  - Existing command address constants: RESET=63, ARM=62, CFG=61.
- Sub-module: instantiate neuron_event_decode; all else is inline (FSM, config bank, counter).

Test Plan:
1. Default drop after rst: event 8'h05, in_valid=1 -> no ev_valid; drop_cnt=1; in_ready stays 1.
2. Arm then forward:
   - Send {in=8'h3E, uio=8'h10} (ARM, arg=1) -> armed=1.
   - Send 8'h45 -> next cycle ev_valid=1, ev_polarity=1, ev_addr=5.
   - Hold ev_ready=0 for 3 cycles -> outputs stable and in_ready=0.
   - Assert ev_ready -> ev_valid=0 the cycle after.
3. CFG writes: uio=8'hA4 (op=1, arg=10) with in=8'h3D -> cfg_leak=4'hA, other cfg_* unchanged. Repeat for ops 0, 2, 3.
4. RESET sweep with NUM_NEURONS=32: in=8'h3F -> clr_en high exactly 32 cycles, clr_addr 0..31; busy=1 throughout; cfg_* back to defaults; armed=0; drop_cnt=0.
5. Boundaries:
   - Armed event addr=40 (>=32) -> dropped and counted.
   - Tick 8'hBF -> forwarded, not treated as RESET.
   - 300 unarmed events -> drop_cnt=255.
6. Reset mid-operation: rst during CLEAR at clr_addr=10 and during DISPATCH with ev_ready=0 -> next cycle all outputs at reset values and no ev_valid.
